// File: rtl/smi_slave.sv
// MDIO/SMI clause 22 responder holding a 32 x 16 register bank.
// Optional feature macro: SMI_SLAVE_PREAMBLE_SUPPRESS_EN (short preamble after a completed frame).
module smi_slave #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned PREAMBLE_MIN = 32,
  parameter int unsigned TIMEOUT_CLKS = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mdc,
  inout  wire         mdio,
  input  logic        link,
  input  logic [1:0]  speed,
  output logic        wr_valid,
  output logic [4:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        rd_valid,
  output logic        busy
);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);
`ifdef SMI_SLAVE_PREAMBLE_SUPPRESS_EN
  localparam bit SUPP_EN = 1'b1;
`else
  localparam bit SUPP_EN = 1'b0;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_RDATA, S_WDATA, S_SKIP
  } state_t;

  state_t          state, state_nxt;
  logic [2:0]      mdc_sr;
  logic [1:0]      mdio_sr;
  logic            rise_c, bit_c, timeout_c, pre_ok_c, bank_we_c;
  logic [5:0]      pre_cnt, pre_nxt;
  logic [4:0]      cnt, cnt_nxt, reg_sr, reg_nxt;
  logic            op_rd, op_rd_nxt, supp, supp_nxt;
  logic            mdio_oe, oe_nxt, mdio_out, out_nxt;
  logic [15:0]     shreg, sh_nxt, rd_word_c;
  logic [TO_W-1:0] to_cnt;
  logic            wr_valid_nxt, rd_valid_nxt;
  logic [4:0]      wr_addr_nxt;
  logic [15:0]     wr_data_nxt;
  logic [15:0]     bank [32];

  assign mdio      = mdio_oe ? mdio_out : 1'bz;
  assign rise_c    = mdc_sr[1] & ~mdc_sr[2];
  assign bit_c     = mdio_sr[1];
  assign timeout_c = (state != S_IDLE) && (to_cnt == TO_LAST);
  assign pre_ok_c  = (32'(pre_cnt) >= PREAMBLE_MIN) || (SUPP_EN && supp && (pre_cnt != 6'd0));

  // Read mux: live status bits override the stored copies
  always_comb begin
    rd_word_c = bank[reg_sr];
    if (reg_sr == 5'd1)       rd_word_c[2]     = link;
    else if (reg_sr == 5'd17) rd_word_c[15:14] = speed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pre_nxt      = pre_cnt;
    cnt_nxt      = cnt;
    op_rd_nxt    = op_rd;
    reg_nxt      = reg_sr;
    sh_nxt       = shreg;
    supp_nxt     = supp;
    oe_nxt       = mdio_oe;
    out_nxt      = mdio_out;
    wr_valid_nxt = 1'b0;
    rd_valid_nxt = 1'b0;
    wr_addr_nxt  = wr_addr;
    wr_data_nxt  = wr_data;
    bank_we_c    = 1'b0;
    if (timeout_c) begin
      state_nxt = S_IDLE;
      pre_nxt   = '0;
      oe_nxt    = 1'b0;
      out_nxt   = 1'b0;
      supp_nxt  = 1'b0;
    end else if (rise_c) begin
      case (state)
        S_IDLE: begin
          if (bit_c) begin
            if (pre_cnt != 6'd63) pre_nxt = pre_cnt + 6'd1;
          end else if (pre_ok_c) begin
            state_nxt = S_ST;
            pre_nxt   = '0;
          end else begin
            pre_nxt = '0;
          end
        end
        S_ST: begin
          cnt_nxt = '0;
          if (bit_c) state_nxt = S_OP;
          else begin
            state_nxt = S_IDLE;
            supp_nxt  = 1'b0;
          end
        end
        S_OP: begin
          sh_nxt  = {shreg[14:0], bit_c};
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd1) begin
            cnt_nxt = '0;
            case ({shreg[0], bit_c})
              2'b10:   begin op_rd_nxt = 1'b1; state_nxt = S_PHYAD; end
              2'b01:   begin op_rd_nxt = 1'b0; state_nxt = S_PHYAD; end
              default: begin state_nxt = S_IDLE; supp_nxt = 1'b0; end
            endcase
          end
        end
        S_PHYAD: begin
          sh_nxt  = {shreg[14:0], bit_c};
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd4) begin
            cnt_nxt   = '0;
            state_nxt = S_REGAD;
          end
        end
        // shreg[8:4] holds PHYAD once the last REGAD bit arrives
        S_REGAD: begin
          sh_nxt  = {shreg[14:0], bit_c};
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd4) begin
            cnt_nxt   = '0;
            reg_nxt   = {shreg[3:0], bit_c};
            state_nxt = (shreg[8:4] == PHY_ADDR) ? S_TA : S_SKIP;
          end
        end
        S_TA: begin
          if (cnt == 5'd0) begin
            cnt_nxt = 5'd1;
            if (op_rd) begin
              sh_nxt  = rd_word_c;
              oe_nxt  = 1'b1;
              out_nxt = 1'b0;
            end
          end else begin
            cnt_nxt = '0;
            if (op_rd) begin
              state_nxt    = S_RDATA;
              out_nxt      = shreg[15];
              sh_nxt       = {shreg[14:0], 1'b0};
              rd_valid_nxt = 1'b1;
            end else begin
              state_nxt = S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (cnt == 5'd15) begin
            state_nxt = S_IDLE;
            pre_nxt   = '0;
            oe_nxt    = 1'b0;
            out_nxt   = 1'b0;
            supp_nxt  = 1'b1;
          end else begin
            out_nxt = shreg[15];
            sh_nxt  = {shreg[14:0], 1'b0};
            cnt_nxt = cnt + 5'd1;
          end
        end
        S_WDATA: begin
          sh_nxt  = {shreg[14:0], bit_c};
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd15) begin
            state_nxt    = S_IDLE;
            pre_nxt      = '0;
            supp_nxt     = 1'b1;
            wr_valid_nxt = 1'b1;
            wr_addr_nxt  = reg_sr;
            wr_data_nxt  = {shreg[14:0], bit_c};
            bank_we_c    = 1'b1;
          end
        end
        S_SKIP: begin
          cnt_nxt = cnt + 5'd1;
          if (cnt == 5'd17) begin
            state_nxt = S_IDLE;
            pre_nxt   = '0;
            supp_nxt  = 1'b0;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Synchronisers, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdc_sr   <= '0;
      mdio_sr  <= '0;
      pre_cnt  <= '0;
      cnt      <= '0;
      op_rd    <= 1'b0;
      reg_sr   <= '0;
      shreg    <= '0;
      supp     <= 1'b0;
      mdio_oe  <= 1'b0;
      mdio_out <= 1'b0;
      to_cnt   <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      rd_valid <= 1'b0;
      busy     <= 1'b0;
    end else begin
      mdc_sr   <= {mdc_sr[1:0], mdc};
      mdio_sr  <= {mdio_sr[0], mdio};
      pre_cnt  <= pre_nxt;
      cnt      <= cnt_nxt;
      op_rd    <= op_rd_nxt;
      reg_sr   <= reg_nxt;
      shreg    <= sh_nxt;
      supp     <= supp_nxt;
      mdio_oe  <= oe_nxt;
      mdio_out <= out_nxt;
      wr_valid <= wr_valid_nxt;
      wr_addr  <= wr_addr_nxt;
      wr_data  <= wr_data_nxt;
      rd_valid <= rd_valid_nxt;
      busy     <= (state_nxt != S_IDLE);
      if (state == S_IDLE || rise_c) to_cnt <= '0;
      else if (to_cnt != TO_LAST)    to_cnt <= to_cnt + TO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) bank[i] <= '0;
    end else if (bank_we_c) begin
      bank[reg_sr] <= wr_data_nxt;
    end
  end
endmodule

// File: tb/tb_smi_slave.sv
// Bench for smi_slave: an SMI master drives frames, a register-map model predicts read data.
module tb_smi_slave;
  localparam logic [4:0]  PHY = 5'd1;
  localparam int unsigned TMO = 200;

  logic        clk = 1'b0, rst_n = 1'b0, mdc = 1'b0, link = 1'b0;
  logic [1:0]  speed = 2'b00;
  logic        m_oe = 1'b0, m_out = 1'b1;
  wire         mdio;
  logic        wr_valid, rd_valid, busy;
  logic [4:0]  wr_addr;
  logic [15:0] wr_data;

  assign mdio = m_oe ? m_out : 1'bz;
  pullup (mdio);

  smi_slave #(.PHY_ADDR(PHY), .PREAMBLE_MIN(32), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .mdc(mdc), .mdio(mdio), .link(link), .speed(speed),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0, checks = 0, rd_pulses = 0, wr_pulses = 0;
  logic [4:0]  last_wa = '0;
  logic [15:0] last_wd = '0;
  logic [15:0] bank_m [32];

  always @(negedge clk) begin
    if (rd_valid) rd_pulses++;
    if (wr_valid) begin
      wr_pulses++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
  end

  function automatic logic [15:0] exp_read(input logic [4:0] ra);
    logic [15:0] v;
    v = bank_m[ra];
    if (ra == 5'd1)  v[2] = link;
    if (ra == 5'd17) v[15:14] = speed;
    return v;
  endfunction

  // One mdc period; smp is what the master sees at the rising edge
  task automatic mdc_bit(input logic drv, input logic val, output logic smp);
    m_oe = drv; m_out = val; mdc = 1'b0;
    #80;
    smp = mdio;
    mdc = 1'b1;
    #80;
  endtask

  task automatic send_head(input int pre, input logic rd, input logic [4:0] pa, input logic [4:0] ra);
    logic s;
    logic [13:0] hdr;
    hdr = {2'b01, (rd ? 2'b10 : 2'b01), pa, ra};
    for (int i = 0; i < pre; i++) mdc_bit(1'b1, 1'b1, s);
    for (int i = 13; i >= 0; i--) mdc_bit(1'b1, hdr[i], s);
  endtask

  task automatic frame(input int pre, input logic rd, input logic [4:0] pa, input logic [4:0] ra,
                       input logic [15:0] wd, output logic ta2, output logic [15:0] rdw,
                       output logic rel);
    logic s;
    send_head(pre, rd, pa, ra);
    rdw = '0;
    if (rd) begin
      mdc_bit(1'b0, 1'b1, s);
      mdc_bit(1'b0, 1'b1, ta2);
      for (int i = 15; i >= 0; i--) begin
        mdc_bit(1'b0, 1'b1, s);
        rdw[i] = s;
      end
    end else begin
      mdc_bit(1'b1, 1'b1, s);
      mdc_bit(1'b1, 1'b0, ta2);
      for (int i = 15; i >= 0; i--) mdc_bit(1'b1, wd[i], s);
    end
    m_oe = 1'b0;
    #10;
    rel = mdio;
  endtask

  task automatic read_partial(input logic [4:0] ra, input int nbits);
    logic s;
    send_head(32, 1'b1, PHY, ra);
    mdc_bit(1'b0, 1'b1, s);
    mdc_bit(1'b0, 1'b1, s);
    for (int i = 0; i < nbits; i++) mdc_bit(1'b0, 1'b1, s);
  endtask

  task automatic do_reset();
    mdc = 1'b0; m_oe = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 32; i++) bank_m[i] = '0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got=%b exp=0", wr_valid); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (mdio !== 1'b1) begin errors++; $display("FAIL reset_mdio_released got=%b exp=1", mdio); end
    checks++; if (wr_addr !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got=%0d exp=0", wr_addr); end
    checks++; if (wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data got=%h exp=0000", wr_data); end
  endtask

  task automatic test_write_read_31();
    logic t, r; logic [15:0] d; int wp, rp;
    wp = wr_pulses;
    frame(32, 1'b0, PHY, 5'd31, 16'h0000, t, d, r);
    bank_m[31] = 16'h0000;
    checks++; if (wr_pulses - wp != 1) begin errors++; $display("FAIL w31_pulses got=%0d exp=1", wr_pulses - wp); end
    checks++; if (last_wa !== 5'd31) begin errors++; $display("FAIL w31_addr got=%0d exp=31", last_wa); end
    checks++; if (last_wd !== 16'h0000) begin errors++; $display("FAIL w31_data got=%h exp=0000", last_wd); end
    rp = rd_pulses;
    frame(32, 1'b1, PHY, 5'd31, 16'h0, t, d, r);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL r31_ta got=%b exp=0", t); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL r31_data got=%h exp=0000", d); end
    checks++; if (rd_pulses - rp != 1) begin errors++; $display("FAIL r31_rd_valid got=%0d exp=1", rd_pulses - rp); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL r31_release got=%b exp=1", r); end
  endtask

  task automatic test_random();
    logic t, r; logic [15:0] d, wd, e; logic [4:0] ra, rb; int wp, rp;
    for (int it = 0; it < 6; it++) begin
      ra = 5'($urandom_range(0, 31));
      wd = 16'($urandom);
      link = 1'($urandom_range(0, 1));
      speed = 2'($urandom_range(0, 3));
      wp = wr_pulses;
      frame(int'($urandom_range(32, 40)), 1'b0, PHY, ra, wd, t, d, r);
      bank_m[ra] = wd;
      checks++; if (wr_pulses - wp != 1) begin errors++; $display("FAIL rnd_wr_pulses it=%0d got=%0d exp=1", it, wr_pulses - wp); end
      checks++; if (last_wa !== ra) begin errors++; $display("FAIL rnd_wr_addr it=%0d got=%0d exp=%0d", it, last_wa, ra); end
      checks++; if (last_wd !== wd) begin errors++; $display("FAIL rnd_wr_data it=%0d got=%h exp=%h", it, last_wd, wd); end
      rb = (it % 2 == 0) ? ra : 5'($urandom_range(0, 31));
      e = exp_read(rb);
      rp = rd_pulses;
      frame(int'($urandom_range(32, 40)), 1'b1, PHY, rb, 16'h0, t, d, r);
      checks++; if (d !== e) begin errors++; $display("FAIL rnd_rd_data it=%0d reg=%0d got=%h exp=%h", it, rb, d, e); end
      checks++; if (t !== 1'b0) begin errors++; $display("FAIL rnd_rd_ta it=%0d got=%b exp=0", it, t); end
      checks++; if (rd_pulses - rp != 1) begin errors++; $display("FAIL rnd_rd_valid it=%0d got=%0d exp=1", it, rd_pulses - rp); end
    end
  endtask

  task automatic test_link();
    logic t, r; logic [15:0] d;
    frame(32, 1'b0, PHY, 5'd1, 16'hA5F8, t, d, r);
    bank_m[1] = 16'hA5F8;
    link = 1'b1;
    frame(32, 1'b1, PHY, 5'd1, 16'h0, t, d, r);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL link1_ta got=%b exp=0", t); end
    checks++; if (d !== 16'hA5FC) begin errors++; $display("FAIL link1_data got=%h exp=a5fc", d); end
    link = 1'b0;
    frame(32, 1'b0, PHY, 5'd1, 16'hFFFF, t, d, r);
    bank_m[1] = 16'hFFFF;
    frame(32, 1'b1, PHY, 5'd1, 16'h0, t, d, r);
    checks++; if (d !== 16'hFFFB) begin errors++; $display("FAIL link0_data got=%h exp=fffb", d); end
  endtask

  task automatic test_speed();
    logic t, r; logic [15:0] d; int rp;
    frame(32, 1'b0, PHY, 5'd17, 16'h4000, t, d, r);
    bank_m[17] = 16'h4000;
    speed = 2'b10;
    rp = rd_pulses;
    frame(32, 1'b1, PHY, 5'd17, 16'h0, t, d, r);
    checks++; if (d !== 16'h8000) begin errors++; $display("FAIL spd_data got=%h exp=8000", d); end
    checks++; if (rd_pulses - rp != 1) begin errors++; $display("FAIL spd_rd_valid got=%0d exp=1", rd_pulses - rp); end
    checks++; if (r !== 1'b1) begin errors++; $display("FAIL spd_release got=%b exp=1", r); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL spd_busy_end got=%b exp=0", busy); end
  endtask

  task automatic test_wrong_phy();
    logic t, r; logic [15:0] d; int wp, rp;
    frame(32, 1'b0, PHY, 5'd31, 16'h0000, t, d, r);
    bank_m[31] = 16'h0000;
    wp = wr_pulses;
    frame(32, 1'b0, 5'd2, 5'd31, 16'hFFFF, t, d, r);
    checks++; if (wr_pulses - wp != 0) begin errors++; $display("FAIL wphy_wr_valid got=%0d exp=0", wr_pulses - wp); end
    rp = rd_pulses;
    frame(32, 1'b1, 5'd2, 5'd31, 16'h0, t, d, r);
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL wphy_ta got=%b exp=1", t); end
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL wphy_undriven got=%h exp=ffff", d); end
    checks++; if (rd_pulses - rp != 0) begin errors++; $display("FAIL wphy_rd_valid got=%0d exp=0", rd_pulses - rp); end
    frame(32, 1'b1, PHY, 5'd31, 16'h0, t, d, r);
    checks++; if (d !== exp_read(5'd31)) begin errors++; $display("FAIL wphy_next got=%h exp=%h", d, exp_read(5'd31)); end
  endtask

  task automatic test_short_preamble();
    logic t, r; logic [15:0] d; int rp;
    do_reset();
    rp = rd_pulses;
    frame(31, 1'b1, PHY, 5'd31, 16'h0, t, d, r);
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL pre31_undriven got=%h exp=ffff", d); end
    checks++; if (rd_pulses - rp != 0) begin errors++; $display("FAIL pre31_rd_valid got=%0d exp=0", rd_pulses - rp); end
    frame(32, 1'b1, PHY, 5'd31, 16'h0, t, d, r);
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL pre32_ta got=%b exp=0", t); end
  endtask

  task automatic test_timeout();
    logic t, r; logic [15:0] d; int rp;
    rp = rd_pulses;
    read_partial(5'd31, 4);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL tmo_busy_mid got=%b exp=1", busy); end
    checks++; if (mdio !== 1'b0) begin errors++; $display("FAIL tmo_driven_mid got=%b exp=0", mdio); end
    checks++; if (rd_pulses - rp != 1) begin errors++; $display("FAIL tmo_rd_valid got=%0d exp=1", rd_pulses - rp); end
    repeat (TMO + 20) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tmo_busy got=%b exp=0", busy); end
    checks++; if (mdio !== 1'b1) begin errors++; $display("FAIL tmo_release got=%b exp=1", mdio); end
    frame(32, 1'b1, PHY, 5'd31, 16'h0, t, d, r);
    checks++; if (t !== 1'b0 || d !== exp_read(5'd31)) begin errors++; $display("FAIL tmo_next got=%b/%h exp=0/%h", t, d, exp_read(5'd31)); end
  endtask

  task automatic test_reset_mid_read();
    logic t, r; logic [15:0] d;
    frame(32, 1'b0, PHY, 5'd5, 16'h1234, t, d, r);
    bank_m[5] = 16'h1234;
    read_partial(5'd31, 6);
    checks++; if (mdio !== 1'b0) begin errors++; $display("FAIL rstmid_driven got=%b exp=0", mdio); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (mdio !== 1'b1) begin errors++; $display("FAIL rstmid_release got=%b exp=1", mdio); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    mdc = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 32; i++) bank_m[i] = '0;
    frame(32, 1'b1, PHY, 5'd5, 16'h0, t, d, r);
    checks++; if (d !== exp_read(5'd5)) begin errors++; $display("FAIL rstmid_bank got=%h exp=%h", d, exp_read(5'd5)); end
  endtask

  task automatic test_back_to_back();
    logic t, r; logic [15:0] d, wd; int rp;
    wd = 16'($urandom) & 16'h7FFE;
    frame(32, 1'b0, PHY, 5'd7, wd, t, d, r);
    bank_m[7] = wd;
    rp = rd_pulses;
    frame(1, 1'b1, PHY, 5'd7, 16'h0, t, d, r);
`ifdef SMI_SLAVE_PREAMBLE_SUPPRESS_EN
    checks++; if (d !== exp_read(5'd7)) begin errors++; $display("FAIL b2b_data got=%h exp=%h", d, exp_read(5'd7)); end
    checks++; if (t !== 1'b0) begin errors++; $display("FAIL b2b_ta got=%b exp=0", t); end
    checks++; if (rd_pulses - rp != 1) begin errors++; $display("FAIL b2b_rd_valid got=%0d exp=1", rd_pulses - rp); end
`else
    checks++; if (d !== 16'hFFFF) begin errors++; $display("FAIL b2b_ignored got=%h exp=ffff", d); end
    checks++; if (t !== 1'b1) begin errors++; $display("FAIL b2b_ta got=%b exp=1", t); end
    checks++; if (rd_pulses - rp != 0) begin errors++; $display("FAIL b2b_rd_valid got=%0d exp=0", rd_pulses - rp); end
`endif
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) bank_m[i] = '0;
    @(negedge clk);
    test_reset();
    test_write_read_31();
    test_random();
    test_link();
    test_speed();
    test_wrong_phy();
    test_short_preamble();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
